// File: rtl/dmem_if.sv
// Request/response bus between the CPU load/store path and dmem_ctrl.
// master = requester (CPU side), slave = controller.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, byte/half/word access with
// extension, error reporting and programmable wait states. Optional MMIO window: DMEM_MMIO_EN.
module dmem_ctrl #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(32'hFFFF_0000)
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out,
  input  logic [31:0] mmio_in
`endif
);

  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q, signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic              size_err, misalign, range_err, mmio0, mmio1, err_d;
  logic [31:0]       mem_word, ld_src, st_base, shifted, ld_ext, mask, wd, wword_d, rdata_d;

  assign idx       = addr_q[IDX_W+1:2];
  assign size_err  = (size_q == 2'b11);
  assign misalign  = ((size_q == 2'b01) && addr_q[0]) ||
                     ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign range_err = |addr_q[ADDR_W-1:IDX_W+2];

`ifdef DMEM_MMIO_EN
  localparam logic [ADDR_W-1:0] MMIO_BASE4 = MMIO_BASE + ADDR_W'(4);
  logic [31:0] mmio_out_q;
  assign mmio0    = (addr_q[ADDR_W-1:2] == MMIO_BASE[ADDR_W-1:2]);
  assign mmio1    = (addr_q[ADDR_W-1:2] == MMIO_BASE4[ADDR_W-1:2]);
  assign mmio_out = mmio_out_q;
`else
  logic unused_mmio;
  assign unused_mmio = ^MMIO_BASE;
  assign mmio0 = 1'b0;
  assign mmio1 = 1'b0;
`endif

  // The MMIO window is exempt from the range check but not from alignment.
  assign err_d = size_err | misalign | (range_err & ~mmio0 & ~mmio1);

  always_comb begin
    mem_word = mem[idx];
    ld_src   = mem_word;
    st_base  = mem_word;
`ifdef DMEM_MMIO_EN
    if (mmio0) begin
      ld_src  = mmio_in;
      st_base = mmio_out_q;
    end else if (mmio1) begin
      ld_src  = mmio_out_q;
      st_base = mmio_out_q;
    end
`endif
  end

  always_comb begin
    shifted = ld_src >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00: begin
        mask   = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        wd     = {4{wdata_q[7:0]}};
        ld_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        mask   = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        wd     = {2{wdata_q[15:0]}};
        ld_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        mask   = 32'hFFFF_FFFF;
        wd     = wdata_q;
        ld_ext = ld_src;
      end
    endcase
    wword_d = (st_base & ~mask) | (wd & mask);
    rdata_d = (err_d || we_q) ? 32'h0 : ld_ext;
  end

  // RAM is not reset; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_ACCESS && we_q && !err_d && !mmio0 && !mmio1)
      mem[idx] <= wword_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
`ifdef DMEM_MMIO_EN
      mmio_out_q  <= 32'h0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            ready_q  <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_LD;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rdata_d;
          rsp_err_q   <= err_d;
          state_q     <= S_RESP;
`ifdef DMEM_MMIO_EN
          if (we_q && !err_d && mmio0) mmio_out_q <= wword_d;
`endif
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
